// File: rtl/parking_pkg.sv
// Shared types and default constants for the parking barrier gate controller.
package parking_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        GRANT_IN  = 2'd1,
        GRANT_OUT = 2'd2,
        HOLD      = 2'd3
    } gate_state_t;

    typedef enum logic {
        LANE_IN  = 1'b0,
        LANE_OUT = 1'b1
    } lane_t;

    localparam int DEF_CAPACITY       = 16;
    localparam int DEF_HOLD_CYCLES    = 8;
    localparam int DEF_TIMEOUT_CYCLES = 64;

    // Bits needed to hold a down-counter load value of max_val-1.
    function automatic int timer_width(input int max_val);
        return (max_val > 1) ? $clog2(max_val) : 1;
    endfunction

endpackage

// File: rtl/parking_timer.sv
// Loadable down-counter shared by the grant timeout and the post-passage hold.
module parking_timer #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] value;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            value <= '0;
        end else if (load) begin
            value <= load_val;
        end else if (value != '0) begin
            value <= value - W'(1);
        end
    end

    assign zero = (value == '0);

endmodule

// File: rtl/parking_gate_ctrl.sv
// Barrier gate arbiter with occupancy count, confirmation timeout and close delay.
// Optional sticky unsolicited-pulse flag enabled by defining PARKING_VIOLATION_EN.
module parking_gate_ctrl
    import parking_pkg::*;
#(
    parameter int CAPACITY       = DEF_CAPACITY,
    parameter int CNT_W          = $clog2(CAPACITY + 1),
    parameter int HOLD_CYCLES    = DEF_HOLD_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req_in,
    input  logic             req_out,
    input  logic             entrada,
    input  logic             salida,
    output logic             gate_open,
    output logic             grant_in,
    output logic             grant_out,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             timeout_err,
    output logic             violation
);

    localparam int TMR_MAX = (HOLD_CYCLES > TIMEOUT_CYCLES) ? HOLD_CYCLES : TIMEOUT_CYCLES;
    localparam int TMR_W   = timer_width(TMR_MAX);

    // Loading N-1 and leaving on zero keeps each phase exactly N cycles long.
    localparam logic [TMR_W-1:0] TMO_LOAD  = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TMR_W-1:0] HOLD_LOAD = TMR_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CAP_VAL   = CNT_W'(CAPACITY);

    gate_state_t      state, state_n;
    lane_t            last_grant, last_grant_n;
    logic [CNT_W-1:0] count_n;
    logic             timeout_n;
    logic             tmr_load;
    logic [TMR_W-1:0] tmr_load_val;
    logic             tmr_zero;
    logic             elig_in, elig_out;

    parking_timer #(
        .W(TMR_W)
    ) u_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (tmr_load),
        .load_val (tmr_load_val),
        .zero     (tmr_zero)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count       <= '0;
            last_grant  <= LANE_OUT;
            timeout_err <= 1'b0;
        end else begin
            count       <= count_n;
            last_grant  <= last_grant_n;
            timeout_err <= timeout_n;
        end
    end

    assign elig_in  = req_in && !full;
    assign elig_out = req_out && (count != '0);

    always_comb begin
        state_n      = state;
        count_n      = count;
        last_grant_n = last_grant;
        timeout_n    = 1'b0;
        tmr_load     = 1'b0;
        tmr_load_val = TMO_LOAD;
        unique case (state)
            IDLE: begin
                if (elig_in && (!elig_out || last_grant == LANE_OUT)) begin
                    state_n      = GRANT_IN;
                    last_grant_n = LANE_IN;
                    tmr_load     = 1'b1;
                end else if (elig_out) begin
                    state_n      = GRANT_OUT;
                    last_grant_n = LANE_OUT;
                    tmr_load     = 1'b1;
                end
            end
            GRANT_IN: begin
                if (entrada) begin
                    if (count != CAP_VAL) begin
                        count_n = count + CNT_W'(1);
                    end
                    state_n      = HOLD;
                    tmr_load     = 1'b1;
                    tmr_load_val = HOLD_LOAD;
                end else if (tmr_zero) begin
                    state_n   = IDLE;
                    timeout_n = 1'b1;
                end
            end
            GRANT_OUT: begin
                if (salida) begin
                    if (count != '0) begin
                        count_n = count - CNT_W'(1);
                    end
                    state_n      = HOLD;
                    tmr_load     = 1'b1;
                    tmr_load_val = HOLD_LOAD;
                end else if (tmr_zero) begin
                    state_n   = IDLE;
                    timeout_n = 1'b1;
                end
            end
            HOLD: begin
                if (tmr_zero) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        gate_open = (state != IDLE);
        grant_in  = (state == GRANT_IN);
        grant_out = (state == GRANT_OUT);
        full      = (count == CAP_VAL);
    end

`ifdef PARKING_VIOLATION_EN
    logic unsolicited;

    always_comb begin
        unsolicited = 1'b0;
        unique case (state)
            GRANT_IN:  unsolicited = salida;
            GRANT_OUT: unsolicited = entrada;
            default:   unsolicited = entrada || salida;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            violation <= 1'b0;
        end else if (unsolicited) begin
            violation <= 1'b1;
        end
    end
`else
    assign violation = 1'b0;
`endif

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Randomised bench for parking_gate_ctrl against a cycle-count reference model,
// preceded by directed scenarios with hand-computed expectations.
module tb_parking_gate_ctrl;

    localparam int CAP  = 2;
    localparam int HOLD = 8;
    localparam int TMO  = 64;
    localparam int CW   = $clog2(CAP + 1);
`ifdef PARKING_VIOLATION_EN
    localparam int VIOL_EN = 1;
`else
    localparam int VIOL_EN = 0;
`endif

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          req_in = 1'b0, req_out = 1'b0, entrada = 1'b0, salida = 1'b0;
    logic          gate_open, grant_in, grant_out, full, timeout_err, violation;
    logic [CW-1:0] count;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: which lane holds the gate, how many cycles remain.
    int m_grant;       // 0 none, 1 entry, 2 exit
    int m_grant_left;
    int m_hold_left;
    int m_count;
    int m_last;        // lane granted most recently: 1 entry, 2 exit
    int m_tmo;
    int m_viol;

    parking_gate_ctrl #(
        .CAPACITY       (CAP),
        .HOLD_CYCLES    (HOLD),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req_in      (req_in),
        .req_out     (req_out),
        .entrada     (entrada),
        .salida      (salida),
        .gate_open   (gate_open),
        .grant_in    (grant_in),
        .grant_out   (grant_out),
        .count       (count),
        .full        (full),
        .timeout_err (timeout_err),
        .violation   (violation)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_grant = 0; m_grant_left = 0; m_hold_left = 0;
        m_count = 0; m_last = 2; m_tmo = 0; m_viol = 0;
    endtask

    task automatic model_step(input bit ri, input bit ro, input bit e, input bit s);
        int pick;
        m_tmo = 0;
        if (m_hold_left > 0) begin
            if (e || s) m_viol = 1;
            m_hold_left--;
        end else if (m_grant != 0) begin
            if ((m_grant == 1 && s) || (m_grant == 2 && e)) m_viol = 1;
            if (m_grant == 1 && e) begin
                if (m_count < CAP) m_count++;
                m_grant = 0;
                m_hold_left = HOLD;
            end else if (m_grant == 2 && s) begin
                if (m_count > 0) m_count--;
                m_grant = 0;
                m_hold_left = HOLD;
            end else begin
                m_grant_left--;
                if (m_grant_left == 0) begin
                    m_grant = 0;
                    m_tmo = 1;
                end
            end
        end else begin
            if (e || s) m_viol = 1;
            pick = 0;
            if (ri && m_count < CAP && ro && m_count > 0) pick = (m_last == 2) ? 1 : 2;
            else if (ri && m_count < CAP) pick = 1;
            else if (ro && m_count > 0) pick = 2;
            if (pick != 0) begin
                m_grant = pick;
                m_last = pick;
                m_grant_left = TMO;
            end
        end
    endtask

    task automatic compare();
        chk("gate_open", gate_open, (m_grant != 0 || m_hold_left > 0) ? 1 : 0);
        chk("grant_in", grant_in, (m_grant == 1) ? 1 : 0);
        chk("grant_out", grant_out, (m_grant == 2) ? 1 : 0);
        chk("count", int'(count), m_count);
        chk("full", full, (m_count == CAP) ? 1 : 0);
        chk("timeout_err", timeout_err, m_tmo);
        chk("violation", violation, m_viol * VIOL_EN);
    endtask

    // Drive one cycle of inputs at the falling edge, then check the result one cycle later.
    task automatic tick(input bit ri, input bit ro, input bit e, input bit s);
        req_in = ri; req_out = ro; entrada = e; salida = s;
        model_step(ri, ro, e, s);
        @(negedge clk);
        compare();
    endtask

    task automatic do_reset();
        req_in = 1'b0; req_out = 1'b0; entrada = 1'b0; salida = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        chk("rst_gate", gate_open, 0);
        chk("rst_grant", grant_in | grant_out, 0);
        chk("rst_count", int'(count), 0);
        chk("rst_full", full, 0);
        chk("rst_flags", timeout_err | violation, 0);
        model_reset();
        @(negedge clk);
        compare();
        reset_n = 1'b1;
    endtask

    task automatic wait_closed(input string name);
        for (int i = 0; i < 40; i++) begin
            if (!gate_open) break;
            tick(0, 0, 0, 0);
        end
        chk(name, gate_open, 0);
    endtask

    initial begin
        int open_cycles;
        int grant_cycles;
        int pm;
        bit ri, ro, e, s;

        model_reset();
        @(negedge clk);
        chk("rst_gate", gate_open, 0);
        chk("rst_count", int'(count), 0);
        chk("rst_full", full, 0);
        chk("rst_viol", violation, 0);
        reset_n = 1'b1;

        // Entry confirmed 3 cycles after grant: open for 1 + 3 + HOLD cycles.
        tick(1, 0, 0, 0);
        chk("t1_grant_in", grant_in, 1);
        open_cycles = 1;
        tick(0, 0, 0, 0);
        tick(0, 0, 0, 0);
        tick(0, 0, 0, 0);
        tick(0, 0, 1, 0);
        for (int i = 0; i < 40; i++) begin
            if (!gate_open) break;
            open_cycles++;
            tick(0, 0, 0, 0);
        end
        open_cycles += 3;
        chk("t1_open_cycles", open_cycles, 4 + HOLD);
        chk("t1_count", int'(count), 1);

        // Second entry fills the lot; further entry requests are refused.
        tick(1, 0, 0, 0);
        tick(0, 0, 1, 0);
        wait_closed("t2_close");
        chk("t2_count", int'(count), 2);
        chk("t2_full", full, 1);
        tick(1, 0, 0, 0);
        tick(1, 0, 0, 0);
        chk("t2_no_grant", grant_in | gate_open, 0);

        // Exit frees a space.
        tick(0, 1, 0, 0);
        chk("t3_grant_out", grant_out, 1);
        tick(0, 0, 0, 1);
        wait_closed("t3_close");
        chk("t3_count", int'(count), 1);
        chk("t3_full", full, 0);

        // Contention: entry wins after an exit, times out, then exit gets the next grant.
        tick(1, 1, 0, 0);
        chk("t4_grant_in", grant_in, 1);
        grant_cycles = 1;
        for (int i = 0; i < 100; i++) begin
            tick(1, 1, 0, 0);
            if (timeout_err) break;
            if (grant_in) grant_cycles++;
        end
        chk("t4_grant_cycles", grant_cycles, TMO);
        chk("t4_timeout", timeout_err, 1);
        chk("t4_gate_low", gate_open, 0);
        chk("t4_count", int'(count), 1);
        tick(1, 1, 0, 0);
        chk("t4_pulse_width", timeout_err, 0);
        chk("t4_grant_out", grant_out, 1);
        tick(0, 0, 0, 1);
        wait_closed("t4_close");
        chk("t4_count_after", int'(count), 0);

        // Unsolicited pulses, then reset while holding with one car inside.
        tick(1, 0, 0, 0);
        tick(0, 0, 0, 1);
        chk("t5_still_grant", grant_in, 1);
        chk("t5_count0", int'(count), 0);
        tick(0, 0, 1, 0);
        tick(0, 0, 1, 0);
        chk("t5_count1", int'(count), 1);
        chk("t5_violation", violation, VIOL_EN);
        chk("t5_hold_open", gate_open, 1);
        do_reset();

        // Randomised traffic with occasional resets.
        pm = 6;
        for (int n = 0; n < 4000; n++) begin
            if (n % 256 == 0) pm = ($urandom_range(0, 2) == 0) ? 1000 : 6;
            if ($urandom_range(0, 599) == 0) begin
                do_reset();
            end else begin
                ri = ($urandom_range(0, 2) != 0);
                ro = ($urandom_range(0, 2) != 0);
                e  = (m_grant == 1 && $urandom_range(0, pm) == 0) || ($urandom_range(0, 39) == 0);
                s  = (m_grant == 2 && $urandom_range(0, pm) == 0) || ($urandom_range(0, 39) == 0);
                tick(ri, ro, e, s);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/parking_gate_ctrl.md
# parking_gate_ctrl

Controller for the single shared barrier gate of the parking lot, sitting downstream of the entry/exit sensor FSM. It arbitrates between an entry requester and an exit requester, opens the gate for the granted lane, waits for the sensor FSM's one-cycle `entrada`/`salida` confirmation pulse, and maintains the occupancy count against a fixed capacity. Missing confirmations are aborted by timeout, and the gate is held open for a fixed close delay after each passage.

## Interface
- `CAPACITY`, 16: number of spaces; entry is refused when count equals CAPACITY.
- `CNT_W`, $clog2(CAPACITY+1): occupancy counter width.
- `HOLD_CYCLES`, 8: cycles the gate stays open after a confirmed passage (≥1).
- `TIMEOUT_CYCLES`, 64: cycles allowed between grant and confirmation (≥1).
- `clk`  in  1  single clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req_in`  in  1  entry lane request (level).
- `req_out`  in  1  exit lane request (level).
- `entrada`  in  1  one-cycle pulse from the sensor FSM: car completed entry.
- `salida`  in  1  one-cycle pulse from the sensor FSM: car completed exit.
- `gate_open`  out  1  barrier open command.
- `grant_in`  out  1  entry lane currently granted.
- `grant_out`  out  1  exit lane currently granted.
- `count`  out  CNT_W  current occupancy.
- `full`  out  1  count == CAPACITY.
- `timeout_err`  out  1  one-cycle pulse when a grant expires unconfirmed.
- `violation`  out  1  sticky unsolicited-pulse flag (see Configuration).

## Operation
- States: IDLE, GRANT_IN, GRANT_OUT, HOLD.
- IDLE: eligible entry = `req_in && !full`; eligible exit = `req_out && count != 0`. Only one eligible → grant it. Both eligible → round-robin: grant the lane not granted last (`last_grant` reset value = exit, so entry wins first contention). Timer loaded with TIMEOUT_CYCLES on grant.
- GRANT_IN: `entrada` → count+1, timer loaded with HOLD_CYCLES, go HOLD. Timer reaches 0 → `timeout_err` pulse, go IDLE, count unchanged.
- GRANT_OUT: same with `salida`, count−1.
- HOLD: timer decrements; at 0 → IDLE. Requests ignored.
- Count saturates: never exceeds CAPACITY, never goes below 0 (guards redundant given grant eligibility, required anyway).
- Pulse not matching current grant (e.g. `salida` in GRANT_IN, any pulse in IDLE/HOLD): count unchanged, state unchanged.
- `entrada` and `salida` together in GRANT_IN: only `entrada` acts; `salida` is unsolicited. Symmetric in GRANT_OUT.
- Request dropped during grant: grant persists until confirmation or timeout.

## Timing
- All outputs registered or decoded from registers; no input-to-output combinational path.
- Reset values: state IDLE, count 0, `full` 0, `gate_open`/`grant_in`/`grant_out`/`timeout_err`/`violation` 0, `last_grant` exit.
- Request in IDLE at cycle N → grant and `gate_open` high from N+1.
- Confirmation pulse at cycle M → count updated and state HOLD at M+1; `gate_open` remains high through HOLD, deasserts HOLD_CYCLES cycles after M+1.
- Timeout: no confirmation for TIMEOUT_CYCLES cycles after grant → `timeout_err` high for exactly one cycle coinciding with return to IDLE; `gate_open` low that cycle.
- Earliest new grant: first cycle after returning to IDLE.
- `reset_n` low mid-grant: immediate return to reset values, gate closes, count cleared.

## Configuration
- `PARKING_VIOLATION_EN` defined: any unsolicited `entrada`/`salida` pulse (per Operation) sets `violation`, held until reset.
- Not defined: `violation` tied to 0; no extra logic.

## Structure
- Package `parking_pkg`: state enum (IDLE, GRANT_IN, GRANT_OUT, HOLD), lane encoding for `last_grant`, default parameter constants.
- Sub-module `parking_timer`: loadable down-counter (load value, load strobe, `zero` flag) shared by timeout and hold phases.

## Test plan
- CAPACITY=2: req_in, `entrada` 3 cycles after grant → count 1, gate open 1 + 3 + HOLD_CYCLES cycles, then closed.
- Two entries confirmed, then req_in → no grant, `full`=1; req_out + `salida` → count 1, `full`=0.
- req_in and req_out both high in IDLE from reset → entry granted first; after completion, with both still high, exit granted.
- Grant entry, no pulse for TIMEOUT_CYCLES=64 → `timeout_err` one-cycle pulse, count unchanged, IDLE.
- `salida` during GRANT_IN and `entrada` during HOLD → count unchanged; `violation`=1 with macro, 0 without.
- `reset_n` low during HOLD with count 1 → all outputs 0 asynchronously, count 0.
